cle_sram_arbiter: RTL and testbench

Shares the single-port 1024x8 label SRAM between two requesters. M0 is the connected-component labeling engine, which reads and writes. M1 is the label readout/post-processing engine, which only reads. The block does round-robin arbitration with an M0 lock for read-modify-write sequences, drives the SRAM port from registers, and routes read data back to the requester that issued the read.

---
 rtl/cle_sram_arbiter_pkg.sv | 22 ++
 rtl/cle_sram_arbiter_if.sv | 40 ++++
 rtl/cle_sram_arbiter_rdpipe.sv | 35 +++
 rtl/cle_sram_arbiter.sv | 132 +++++++++++++
 tb/tb_cle_sram_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cle_sram_arbiter_pkg.sv
// Shared types and defaults for the label SRAM arbiter.
package cle_arb_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

endpackage

// File: rtl/cle_sram_arbiter_if.sv
// Requester, SRAM and debug signals of the label SRAM arbiter.
// Handshake: an access is accepted on a rising edge where mX_req & mX_gnt
// is high; gnt is combinational and never asserted for both requesters.
// mX_rvalid is a one-cycle pulse marking rdata as belonging to requester X.
interface cle_sram_arbiter_if;
  import cle_arb_pkg::*;

  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_lock;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic              m1_req;
  logic [ADDR_W-1:0] m1_addr;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_d;
  logic              sram_wen;
  logic [DATA_W-1:0] sram_q;
  arb_state_e        dbg_state;

  // Arbiter side
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_lock, m1_req, m1_addr, sram_q,
    output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata, sram_a, sram_d,
           sram_wen, dbg_state
  );

  // Requester / SRAM environment side
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_lock, m1_req, m1_addr, sram_q,
    input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata, sram_a, sram_d,
           sram_wen, dbg_state
  );

endinterface

// File: rtl/cle_sram_arbiter_rdpipe.sv
// Read-return path: two-stage {valid, owner} tag pipeline aligned with the
// SRAM read latency, the shared rdata register and per-owner rvalid decode.
module cle_arb_rdpipe
  import cle_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  rd_tag_t           i_tag,
  input  logic [DATA_W-1:0] i_sram_q,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_m0_rvalid,
  output logic              o_m1_rvalid
);

  rd_tag_t r_tag1;
  rd_tag_t r_tag2;

  // Tag travels alongside the SRAM access; reset drops any in-flight read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag1      <= '{valid: 1'b0, owner: OWN_M0};
      r_tag2      <= '{valid: 1'b0, owner: OWN_M0};
      o_rdata     <= '0;
      o_m0_rvalid <= 1'b0;
      o_m1_rvalid <= 1'b0;
    end else begin
      r_tag1      <= i_tag;
      r_tag2      <= r_tag1;
      if (r_tag2.valid) o_rdata <= i_sram_q;
      o_m0_rvalid <= r_tag2.valid && (r_tag2.owner == OWN_M0);
      o_m1_rvalid <= r_tag2.valid && (r_tag2.owner == OWN_M1);
    end
  end

endmodule

// File: rtl/cle_sram_arbiter.sv
// Round-robin arbiter for the single-port label SRAM with an M0 lock for
// read-modify-write sequences. SRAM port is driven from registers.
// Optional feature macro: CLE_ARB_LOCK_LIMIT_EN bounds the lock duration
// to LOCK_MAX cycles and then hands the next tie to M1.
module cle_sram_arbiter
  import cle_arb_pkg::*;
#(
  parameter int LOCK_MAX = 16
) (
  input  logic               clk,
  input  logic               reset,
  cle_sram_arbiter_if.slave  bus
);

  arb_state_e r_state;
  arb_state_e w_next_state;
  owner_e     r_last;
  logic       w_m0_gnt;
  logic       w_m1_gnt;
  logic       w_acc0;
  logic       w_acc1;
  logic       w_limit_hit;
  rd_tag_t    w_tag;

  logic [ADDR_W-1:0] r_sram_a;
  logic [DATA_W-1:0] r_sram_d;
  logic              r_sram_wen;

  assign w_acc0 = bus.m0_req & w_m0_gnt;
  assign w_acc1 = bus.m1_req & w_m1_gnt;

`ifdef CLE_ARB_LOCK_LIMIT_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  logic [CNT_W-1:0] r_lock_cnt;

  // Counts LOCKED cycles; held at zero while OPEN so each entry starts fresh.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_lock_cnt <= '0;
    else if (r_state == ARB_OPEN) r_lock_cnt <= '0;
    else r_lock_cnt <= r_lock_cnt + CNT_W'(1);
  end

  // Fires on the edge at which the counter reaches LOCK_MAX.
  assign w_limit_hit = (r_state == ARB_LOCKED) &&
                       (r_lock_cnt == CNT_W'(LOCK_MAX - 1));
`else
  // Unbounded lock: never fires for any legal LOCK_MAX.
  assign w_limit_hit = (LOCK_MAX < 0);
`endif

  // Lock FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ARB_OPEN;
    else r_state <= w_next_state;
  end

  // Lock FSM next state: enter on a locked M0 access, leave when M0 lets go
  // (or when the optional limit expires).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_OPEN:   if (w_acc0 && bus.m0_lock) w_next_state = ARB_LOCKED;
      ARB_LOCKED: if (w_limit_hit || !bus.m0_lock) w_next_state = ARB_OPEN;
      default:    w_next_state = ARB_OPEN;
    endcase
  end

  // Lock FSM outputs: combinational grants, suppressed during reset.
  always_comb begin
    w_m0_gnt = 1'b0;
    w_m1_gnt = 1'b0;
    if (!reset) begin
      case (r_state)
        ARB_OPEN: begin
          w_m0_gnt = bus.m0_req && (!bus.m1_req || r_last == OWN_M1);
          w_m1_gnt = bus.m1_req && (!bus.m0_req || r_last == OWN_M0);
        end
        ARB_LOCKED: w_m0_gnt = bus.m0_req;
        default: ;
      endcase
    end
  end

  // Round-robin pointer: last owner, or M0 when a lock is cut short so M1
  // takes the following tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_last <= OWN_M1;
    else if (w_limit_hit) r_last <= OWN_M0;
    else if (w_acc0) r_last <= OWN_M0;
    else if (w_acc1) r_last <= OWN_M1;
  end

  // SRAM port registers: address/data captured at accept, wen low only for
  // M0 writes; sram_a/sram_d hold when nothing is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sram_a   <= '0;
      r_sram_d   <= '0;
      r_sram_wen <= 1'b1;
    end else if (w_acc0) begin
      r_sram_a   <= bus.m0_addr;
      r_sram_wen <= ~bus.m0_we;
      if (bus.m0_we) r_sram_d <= bus.m0_wdata;
    end else if (w_acc1) begin
      r_sram_a   <= bus.m1_addr;
      r_sram_wen <= 1'b1;
    end else begin
      r_sram_wen <= 1'b1;
    end
  end

  assign w_tag.valid = (w_acc0 && !bus.m0_we) || w_acc1;
  assign w_tag.owner = w_acc1 ? OWN_M1 : OWN_M0;

  cle_arb_rdpipe u_rdpipe (
    .clk         (clk),
    .reset       (reset),
    .i_tag       (w_tag),
    .i_sram_q    (bus.sram_q),
    .o_rdata     (bus.rdata),
    .o_m0_rvalid (bus.m0_rvalid),
    .o_m1_rvalid (bus.m1_rvalid)
  );

  assign bus.m0_gnt    = w_m0_gnt;
  assign bus.m1_gnt    = w_m1_gnt;
  assign bus.sram_a    = r_sram_a;
  assign bus.sram_d    = r_sram_d;
  assign bus.sram_wen  = r_sram_wen;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_cle_sram_arbiter.sv
// Bench for cle_sram_arbiter: SRAM model, directed scenarios with literal
// expectations, and a cycle-by-cycle reference model compared on negedges.
module tb_cle_sram_arbiter;
  import cle_arb_pkg::*;

  localparam int LOCK_MAX = 4;
`ifdef CLE_ARB_LOCK_LIMIT_EN
  localparam bit LIMIT_ON = 1'b1;
`else
  localparam bit LIMIT_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cle_sram_arbiter_if bus();

  cle_sram_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- SRAM model ----------------
  logic [DATA_W-1:0] mem     [1024];
  logic [DATA_W-1:0] mem_ref [1024];

  always @(posedge clk) begin
    if (!bus.sram_wen) mem[bus.sram_a] <= bus.sram_d;
    bus.sram_q <= mem[bus.sram_a];
  end

  // ---------------- counters / check ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic              m_last;      // 0 = M0 owned last access, 1 = M1
  logic              m_locked;
  int                m_lock_cycles;
  int                m_edges;
  logic [DATA_W-1:0] m_rdata;
  logic [ADDR_W-1:0] m_sram_a;
  logic [DATA_W-1:0] m_sram_d;
  logic              m_sram_wen;
  logic [8:0]        exp_q[$];    // {owner, data} of reads in flight
  int                due_q[$];    // edge count at which each read returns

  task automatic model_reset();
    m_last = 1'b1;
    m_locked = 1'b0;
    m_lock_cycles = 0;
    m_edges = 0;
    m_rdata = '0;
    m_sram_a = '0;
    m_sram_d = '0;
    m_sram_wen = 1'b1;
    exp_q.delete();
    due_q.delete();
  endtask

  task automatic model_grants(output logic g0, output logic g1);
    g0 = 1'b0;
    g1 = 1'b0;
    if (!reset) begin
      if (m_locked) g0 = bus.m0_req;
      else if (bus.m0_req && bus.m1_req) begin
        if (m_last) g0 = 1'b1;
        else g1 = 1'b1;
      end else begin
        g0 = bus.m0_req;
        g1 = bus.m1_req;
      end
    end
  endtask

  // Compare on every negedge, then advance the model across the next posedge.
  always @(negedge clk) begin
    logic g0, g1, rv0, rv1;
    logic [8:0] ent;
    if (reset) model_reset();
    model_grants(g0, g1);
    rv0 = 1'b0;
    rv1 = 1'b0;
    if (due_q.size() > 0 && due_q[0] == m_edges) begin
      void'(due_q.pop_front());
      ent = exp_q.pop_front();
      m_rdata = ent[7:0];
      rv0 = ~ent[8];
      rv1 = ent[8];
    end
    check("m0_gnt", bus.m0_gnt, g0);
    check("m1_gnt", bus.m1_gnt, g1);
    check("m0_rvalid", bus.m0_rvalid, rv0);
    check("m1_rvalid", bus.m1_rvalid, rv1);
    check("rdata", bus.rdata, m_rdata);
    check("sram_a", bus.sram_a, m_sram_a);
    check("sram_d", bus.sram_d, m_sram_d);
    check("sram_wen", bus.sram_wen, m_sram_wen);
    check("state", bus.dbg_state, m_locked ? ARB_LOCKED : ARB_OPEN);
    if (!reset) begin
      m_edges++;
      m_sram_wen = 1'b1;
      if (bus.m0_req && g0) begin
        m_last = 1'b0;
        m_sram_a = bus.m0_addr;
        if (bus.m0_we) begin
          m_sram_d = bus.m0_wdata;
          m_sram_wen = 1'b0;
          mem_ref[bus.m0_addr] = bus.m0_wdata;
        end else begin
          exp_q.push_back({1'b0, mem_ref[bus.m0_addr]});
          due_q.push_back(m_edges + 2);
        end
      end else if (bus.m1_req && g1) begin
        m_last = 1'b1;
        m_sram_a = bus.m1_addr;
        exp_q.push_back({1'b1, mem_ref[bus.m1_addr]});
        due_q.push_back(m_edges + 2);
      end
      if (!m_locked) begin
        if (bus.m0_req && g0 && bus.m0_lock) begin
          m_locked = 1'b1;
          m_lock_cycles = 0;
        end
      end else begin
        m_lock_cycles++;
        if (LIMIT_ON && m_lock_cycles == LOCK_MAX) begin
          m_locked = 1'b0;
          m_last = 1'b0;
        end else if (!bus.m0_lock) begin
          m_locked = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.m0_req = 1'b0;
    bus.m0_we = 1'b0;
    bus.m0_lock = 1'b0;
    bus.m1_req = 1'b0;
  endtask

  task automatic m0_drive(input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic lock);
    bus.m0_req = 1'b1;
    bus.m0_we = we;
    bus.m0_addr = a;
    bus.m0_wdata = d;
    bus.m0_lock = lock;
  endtask

  task automatic m1_drive(input logic [ADDR_W-1:0] a);
    bus.m1_req = 1'b1;
    bus.m1_addr = a;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int g1cnt;
    logic exp_limit_gnt;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 8'(i) ^ 8'h5A;
      mem_ref[i] = 8'(i) ^ 8'h5A;
    end
    mem[10'h025] = 8'h07;
    mem_ref[10'h025] = 8'h07;
    idle_all();
    bus.m0_addr = '0;
    bus.m0_wdata = '0;
    bus.m1_addr = '0;

    // Reset: outputs at reset values, grants forced low.
    reset = 1'b1;
    repeat (2) tick();
    bus.m0_req = 1'b1;
    #2;
    check("rst_m0_gnt_forced", bus.m0_gnt, 1'b0);
    check("rst_sram_wen", bus.sram_wen, 1'b1);
    check("rst_rdata", bus.rdata, 8'h00);
    bus.m0_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Single M0 read of 0x025 -> 0x07 two cycles after accept.
    m0_drive(1'b0, 10'h025, 8'h00, 1'b0);
    #2;
    check("t1_m0_gnt", bus.m0_gnt, 1'b1);
    tick();
    idle_all();
    tick();
    tick();
    #2;
    check("t1_m0_rvalid", bus.m0_rvalid, 1'b1);
    check("t1_rdata", bus.rdata, 8'h07);
    tick();

    // Both requesting reads: grants alternate (M0 owned last, so M1 first).
    for (int i = 0; i < 6; i++) begin
      m0_drive(1'b0, 10'(10'h040 + i), 8'h00, 1'b0);
      m1_drive(10'(10'h080 + i));
      if (i == 0) begin
        #2;
        check("t2_first_tie_m1", bus.m1_gnt, 1'b1);
      end
      tick();
    end
    idle_all();
    repeat (3) tick();

    // Lock: M0 writes 0x3FF<-0xAB with lock, M1 is blocked while M0 idles.
    m0_drive(1'b1, 10'h3FF, 8'hAB, 1'b1);
    #2;
    check("t3_m0_gnt_lock", bus.m0_gnt, 1'b1);
    tick();
    bus.m0_req = 1'b0;
    bus.m0_we = 1'b0;
    m1_drive(10'h3FF);
    for (int k = 0; k < 3; k++) begin
      #2;
      check("t3_m1_blocked", bus.m1_gnt, 1'b0);
      if (k > 0) check("t3_no_access_wen", bus.sram_wen, 1'b1);
      tick();
    end
    bus.m0_lock = 1'b0;
    #2;
    check("t3_m1_blocked_drop", bus.m1_gnt, 1'b0);
    tick();
    #2;
    check("t3_m1_gnt_unlock", bus.m1_gnt, 1'b1);
    tick();
    idle_all();
    tick();
    tick();
    #2;
    check("t3_m1_rvalid", bus.m1_rvalid, 1'b1);
    check("t3_rdata_ab", bus.rdata, 8'hAB);
    tick();

    // Reset one cycle after an M1 accept: the read is discarded.
    m1_drive(10'h010);
    tick();
    idle_all();
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #2;
      check("t4_no_m1_rvalid", bus.m1_rvalid, 1'b0);
      check("t4_rdata_zero", bus.rdata, 8'h00);
      tick();
    end

    // Lock held indefinitely while M1 requests.
    m0_drive(1'b0, 10'h001, 8'h00, 1'b1);
    m1_drive(10'h002);
    #2;
    check("t5_first_tie_m0", bus.m0_gnt, 1'b1);
    tick();
    g1cnt = 0;
    for (int k = 0; k < LOCK_MAX; k++) begin
      #2;
      g1cnt += int'(bus.m1_gnt);
      tick();
    end
    check("t5_locked_no_m1", g1cnt, 0);
`ifdef CLE_ARB_LOCK_LIMIT_EN
    exp_limit_gnt = 1'b1;
`else
    exp_limit_gnt = 1'b0;
`endif
    #2;
    check("t5_limit_m1_gnt", bus.m1_gnt, exp_limit_gnt);
    idle_all();
    repeat (3) tick();

    // M0 write 0x100<-0x11 then M1 read of 0x100 on the next accept.
    m0_drive(1'b1, 10'h100, 8'h11, 1'b0);
    tick();
    idle_all();
    m1_drive(10'h100);
    #2;
    check("t6_wr_wen_low", bus.sram_wen, 1'b0);
    check("t6_m1_gnt", bus.m1_gnt, 1'b1);
    tick();
    idle_all();
    #2;
    check("t6_rd_wen_high", bus.sram_wen, 1'b1);
    tick();
    tick();
    #2;
    check("t6_m1_rvalid", bus.m1_rvalid, 1'b1);
    check("t6_rdata_11", bus.rdata, 8'h11);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
